// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: N-channel request bus plus one registered output beat.
// slave: arbiter side; master: requesters plus downstream sink.
interface rr_mux_n_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_last;
  logic               out_ready;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-to-1 round-robin selector with burst lock and a registered
// output stage (1-cycle latency, 1 beat/cycle).
// Ports: clk, rst_n (async, active-low), bus (rr_mux_n_if.slave:
//   in_valid/in_last/in_data/in_ready, out_valid/out_data/out_sel/
//   out_last/out_ready).
// Option RR_MUX_STALL_CNT_EN adds stall_clr (in) and stall_cnt[15:0] (out),
//   a saturating count of cycles with out_valid=1 and out_ready=0.
module rr_mux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef RR_MUX_STALL_CNT_EN
  input  logic        stall_clr,
  output logic [15:0] stall_cnt,
`endif
  rr_mux_n_if.slave   bus
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t            state, state_nx;
  logic [SELW-1:0]   rr_ptr, ptr_nx;
  logic [SELW-1:0]   grant;
  logic              found;
  logic              load_ok;
  logic              take;
  logic [N-1:0]      ready;
  int                idx;

  logic              vld_q;
  logic [WIDTH-1:0]  data_q;
  logic [SELW-1:0]   sel_q;
  logic              last_q;

  assign load_ok = !vld_q || bus.out_ready;

  // In LOCK the locked channel is rr_ptr: it was set to the grant
  // on the first beat and is left alone until the burst ends.
  always_comb begin
    state_nx = state;
    ptr_nx   = rr_ptr;
    grant    = '0;
    found    = 1'b0;
    idx      = 0;
    ready    = '0;
    take     = 1'b0;
    case (state)
      ARB: begin
        for (int k = 1; k <= N; k++) begin
          idx = (int'(rr_ptr) + k) % N;
          if (!found && bus.in_valid[idx]) begin
            grant = SELW'(idx);
            found = 1'b1;
          end
        end
      end
      LOCK: begin
        grant = rr_ptr;
        found = bus.in_valid[rr_ptr];
      end
      default: ;
    endcase
    take = rst_n && load_ok && found;
    if (take) begin
      ready[grant] = 1'b1;
      ptr_nx       = grant;
      if (state == ARB && !bus.in_last[grant])
        state_nx = LOCK;
      else if (state == LOCK && bus.in_last[grant])
        state_nx = ARB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB;
      rr_ptr <= SELW'(N - 1);
    end else begin
      state  <= state_nx;
      rr_ptr <= ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      last_q <= 1'b0;
    end else if (take) begin
      vld_q  <= 1'b1;
      data_q <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
      sel_q  <= grant;
      last_q <= bus.in_last[grant];
    end else if (bus.out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last_q;

`ifdef RR_MUX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (vld_q && !bus.out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed stimulus for rr_mux_n (N=4, WIDTH=8).
// Covers reset, round-robin, burst lock, back-pressure, sparse, mid-burst reset.
module tb_rr_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_mux_n_if #(.WIDTH(8), .N(4)) bus ();

`ifdef RR_MUX_STALL_CNT_EN
  logic        stall_clr;
  logic [15:0] stall_cnt;
`endif

  rr_mux_n #(.WIDTH(8), .N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RR_MUX_STALL_CNT_EN
    .stall_clr (stall_clr),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 4'b0001;
    bus.in_last   = 4'b1111;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.out_ready = 1'b1;
`ifdef RR_MUX_STALL_CNT_EN
    stall_clr     = 1'b0;
`endif
    #2;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data",  32'(bus.out_data),  32'h0);
    chk("rst_sel",   32'(bus.out_sel),   32'h0);
    chk("rst_last",  32'(bus.out_last),  32'h0);
    chk("rst_ready", 32'(bus.in_ready),  32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.in_ready), 32'h1);

    bus.in_valid = 4'b1111;
    #1;
    chk("rr_ready0", 32'(bus.in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_valid", 32'(bus.out_valid), 32'h1);
      chk("rr_sel",   32'(bus.out_sel),   32'(i % 4));
      chk("rr_data",  32'(bus.out_data),  32'(8'hA0 + (i % 4)));
    end

    bus.in_valid = 4'b0110;
    bus.in_last  = 4'b1101;
    #1;
    chk("bl_ready0", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bl_sel0", 32'(bus.out_sel),  32'h1);
    chk("bl_lst0", 32'(bus.out_last), 32'h0);
    chk("bl_ready1", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bl_sel1", 32'(bus.out_sel), 32'h1);
    bus.in_last = 4'b1111;
    #1;
    chk("bl_ready2", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bl_sel2", 32'(bus.out_sel),  32'h1);
    chk("bl_lst2", 32'(bus.out_last), 32'h1);
    chk("bl_ready3", 32'(bus.in_ready), 32'h4);
    bus.in_valid = 4'b0100;
    tick();
    chk("bl_sel3",  32'(bus.out_sel),  32'h2);
    chk("bl_data3", 32'(bus.out_data), 32'hA2);

    bus.in_valid = 4'b0001;
    bus.in_data[7:0] = 8'h5A;
    #1;
    chk("bp_ready0", 32'(bus.in_ready), 32'h1);
    tick();
    bus.out_ready = 1'b0;
    bus.in_data[7:0] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 32'(bus.in_ready),  32'h0);
      chk("bp_data",  32'(bus.out_data),  32'h5A);
      chk("bp_valid", 32'(bus.out_valid), 32'h1);
      tick();
    end
    chk("bp_sel", 32'(bus.out_sel), 32'h0);
`ifdef RR_MUX_STALL_CNT_EN
    chk("bp_stall", 32'(stall_cnt), 32'd5);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("bp_clr", 32'(stall_cnt), 32'd0);
    tick();
    chk("bp_inc", 32'(stall_cnt), 32'd1);
`endif
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drain", 32'(bus.out_valid), 32'h0);
    chk("bp_data_hold", 32'(bus.out_data), 32'h5A);

    bus.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sp_sel",   32'(bus.out_sel),   32'h3);
      chk("sp_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_sel", 32'(bus.out_sel), (i % 2 == 0) ? 32'h0 : 32'h3);
    end

    bus.in_valid = 4'b0010;
    bus.in_last  = 4'b1101;
    tick();
    chk("mr_sel", 32'(bus.out_sel), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.out_valid), 32'h0);
    chk("mr_sel0",  32'(bus.out_sel),   32'h0);
    chk("mr_ready", 32'(bus.in_ready),  32'h0);
    tick();
    rst_n        = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_last  = 4'b1111;
    #1;
    chk("mr_arb", 32'(bus.in_ready), 32'h4);
    tick();
    chk("mr_sel2", 32'(bus.out_sel), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
